hex_display_scheduler: RTL and testbench
========================================

# hex_display_scheduler

Time-slicing scheduler that shares the four-digit seven-segment display between up to NUM_SRC requesters. Each requester presents a 16-bit value and a valid flag. The scheduler rotates round-robin through the valid requesters, holding each one for a fixed dwell time. Its registered 16-bit output drives the HEX input of the display driver directly. A manual pin override and a skip pulse let board switches and buttons select or step through the sources.

## Interface
- NUM_SRC, 4: number of requesters, 2..16; SEL_W = $clog2(NUM_SRC).
- DWELL_CYCLES, 100_000_000: CLK cycles each source is shown (1 s at 100 MHz); must be ≥ 2.
- CLK  in  1  100 MHz system clock.
- RST  in  1  reset, asynchronous, active-high.
- SRC_VALID  in  NUM_SRC  bit i set when requester i wants display time.
- SRC_DATA  in  16*NUM_SRC  requester i value in bits [16*i +: 16].
- PIN_EN  in  1  level; forces display of PIN_SEL.
- PIN_SEL  in  SEL_W  source to pin.
- ADVANCE  in  1  single-cycle pulse (already debounced); skip to the next valid source.
- HEX  out  16  value shown; drives the display driver.
- CUR_SRC  out  SEL_W  index of the source currently shown.
- DISPLAY_ON  out  1  high when HEX carries a source value.

## Operation
- States:
  - IDLE: nothing to show.
  - SHOW: rotating.
  - PINNED: manual override.
- Reset, asynchronous: state IDLE, HEX=16'h0000, CUR_SRC=0, DISPLAY_ON=0, dwell counter=0.
- "next(c)": the lowest-numbered valid index after c in circular order, wrapping from NUM_SRC-1 to 0. If c is the only valid source, next(c)=c.
- IDLE:
  - If PIN_EN=1: go to PINNED with CUR_SRC=PIN_SEL.
  - Else if any SRC_VALID bit is set: go to SHOW with CUR_SRC = lowest valid index and counter=0.
  - Else: stay in IDLE with HEX=0.
- SHOW, evaluated in this precedence order each cycle:
  1. PIN_EN=1: go to PINNED with CUR_SRC=PIN_SEL.
  2. SRC_VALID[CUR_SRC]=0: if no source is valid, go to IDLE. Otherwise set CUR_SRC=next(CUR_SRC) and counter=0.
  3. counter==DWELL_CYCLES-1 or ADVANCE=1: set CUR_SRC=next(CUR_SRC) and counter=0. When both occur in the same cycle, the source advances once.
  4. Otherwise: counter+1.
- PINNED:
  - CUR_SRC follows PIN_SEL every cycle. The counter is held at 0 and ADVANCE is ignored.
  - SRC_VALID is ignored: the pinned value is shown regardless of its valid flag.
  - On PIN_EN falling: if SRC_VALID[CUR_SRC]=1, go to SHOW on the same source with counter=0. Else, if any source is valid, go to SHOW with CUR_SRC=next(CUR_SRC). Else go to IDLE.
- ADVANCE is ignored in IDLE.
- HEX on every edge:
  - IDLE: HEX <= 0.
  - Otherwise: HEX <= SRC_DATA of the CUR_SRC value being loaded on that same edge.
  - As a result, HEX and CUR_SRC always agree, and HEX tracks live changes in the displayed source's data.
- DISPLAY_ON is registered: 1 in SHOW and PINNED, 0 in IDLE.
- An out-of-range PIN_SEL (≥ NUM_SRC) maps to source 0.
- The counter is $clog2(DWELL_CYCLES) bits wide and never exceeds DWELL_CYCLES-1.

## Timing
- All outputs are registered. Data latency is 1 cycle: a change on SRC_DATA in cycle t appears on HEX after edge t+1.
- Without ADVANCE or drops, each source is shown for exactly DWELL_CYCLES cycles.
- Control-input latency is 1 cycle:
  - A valid drop, ADVANCE, or PIN_EN change sampled at edge t is reflected in CUR_SRC, HEX and DISPLAY_ON after edge t.
  - First display from IDLE likewise appears 1 cycle after SRC_VALID rises.
- RST asserted mid-rotation clears all outputs immediately. The first display after release follows the IDLE rule above.

## Test plan
(Bench uses DWELL_CYCLES=4 and SRC_DATA = {16'h3333, 16'h2222, 16'h1111, 16'h0000}.)
- Reset check:
  - Stimulus: reset with all inputs 0.
  - Required: HEX=0000, CUR_SRC=0, DISPLAY_ON=0. Raising all SRC_VALID gives HEX=0000 and DISPLAY_ON=1 after one edge.
- Full rotation:
  - Stimulus: SRC_VALID=4'b1111.
  - Required: CUR_SRC sequence is 0,1,2,3,0, holding each value for exactly 4 cycles. HEX is 0000, 1111, 2222, 3333 in step.
- Skip and drop:
  - Stimulus: SRC_VALID=4'b1010; then clear bit 3 while source 3 is shown.
  - Required: rotation alternates 1→3→1. After the drop, the next edge shows CUR_SRC=1, HEX=1111, counter restarted. Clearing all bits gives IDLE, HEX=0000, DISPLAY_ON=0.
- ADVANCE collision:
  - Stimulus: ADVANCE pulse on the dwell-expiry cycle while showing source 1.
  - Required: CUR_SRC=2 (not 3), and it holds 4 cycles. An ADVANCE pulse mid-dwell on source 2 gives CUR_SRC=3 on the next edge.
- Pin override:
  - Stimulus: PIN_EN=1, PIN_SEL=2, SRC_VALID[2]=0; then change SRC_DATA[2] to 16'hBEEF; then drop PIN_EN.
  - Required: during the pin, HEX=2222 then BEEF one cycle after the data change, with no rotation. After PIN_EN falls, CUR_SRC=next(2)=3.
- Reset mid-rotation:
  - Stimulus: assert RST asynchronously while source 2 is shown, then release.
  - Required: outputs clear immediately. Rotation restarts at source 0 with a full 4-cycle dwell.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// Round-robin time-slicer sharing one 4-digit hex display among NUM_SRC requesters,
// with pin override and skip. All outputs registered; control and data latency 1 cycle.
module hex_display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  localparam int SEL_W       = $clog2(NUM_SRC),
  localparam int CNT_W       = $clog2(DWELL_CYCLES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_SRC-1:0]    SRC_VALID,
  input  logic [16*NUM_SRC-1:0] SRC_DATA,
  input  logic                  PIN_EN,
  input  logic [SEL_W-1:0]      PIN_SEL,
  input  logic                  ADVANCE,
  output logic [15:0]           HEX,
  output logic [SEL_W-1:0]      CUR_SRC,
  output logic                  DISPLAY_ON
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_PINNED
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cur_src_q, cur_src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        hex_q, hex_d;
  logic               on_q, on_d;

  logic               any_vld;
  logic               cur_vld;
  logic               dwell_done;
  logic [SEL_W-1:0]   pin_idx;
  logic [SEL_W-1:0]   first_idx;
  logic [SEL_W-1:0]   next_idx;

  // Scanning downward lets the closest valid index after c win; c itself is the fallback.
  function automatic logic [SEL_W-1:0] next_src(input logic [SEL_W-1:0] c,
                                                input logic [NUM_SRC-1:0] v);
    logic [SEL_W-1:0] r;
    int               idx;
    r = c;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      idx = (int'(c) + k) % NUM_SRC;
      if (v[idx]) r = idx[SEL_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] lowest_src(input logic [NUM_SRC-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = i[SEL_W-1:0];
    end
    return r;
  endfunction

  always_comb begin
    any_vld    = |SRC_VALID;
    cur_vld    = SRC_VALID[cur_src_q];
    dwell_done = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    pin_idx    = (int'(PIN_SEL) < NUM_SRC) ? PIN_SEL : '0;
    first_idx  = lowest_src(SRC_VALID);
    next_idx   = next_src(cur_src_q, SRC_VALID);
  end

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cnt_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (PIN_EN) begin
          state_d   = ST_PINNED;
          cur_src_d = pin_idx;
        end else if (any_vld) begin
          state_d   = ST_SHOW;
          cur_src_d = first_idx;
        end
      end

      ST_SHOW: begin
        if (PIN_EN) begin
          state_d   = ST_PINNED;
          cur_src_d = pin_idx;
        end else if (!cur_vld) begin
          if (!any_vld) begin
            state_d = ST_IDLE;
          end else begin
            cur_src_d = next_idx;
          end
        end else if (dwell_done || ADVANCE) begin
          // Expiry and skip landing together still move only one step.
          cur_src_d = next_idx;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PINNED: begin
        if (PIN_EN) begin
          cur_src_d = pin_idx;
        end else if (cur_vld) begin
          state_d = ST_SHOW;
        end else if (any_vld) begin
          state_d   = ST_SHOW;
          cur_src_d = next_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cur_src_d = '0;
      end
    endcase

    // HEX is loaded from the same index CUR_SRC takes, so the two never disagree.
    hex_d = (state_d == ST_IDLE) ? 16'h0000 : SRC_DATA[16*int'(cur_src_d) +: 16];
    on_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cur_src_q <= '0;
      cnt_q     <= '0;
      hex_q     <= 16'h0000;
      on_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      on_q      <= on_d;
    end
  end

  assign HEX        = hex_q;
  assign CUR_SRC    = cur_src_q;
  assign DISPLAY_ON = on_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: directed scenarios plus random traffic against a
// cycle-level reference model of the scheduling rules.
module tb_hex_display_scheduler;

  localparam int NSRC  = 4;
  localparam int DWELL = 4;

  logic            CLK;
  logic            RST;
  logic [3:0]      SRC_VALID;
  logic [63:0]     SRC_DATA;
  logic            PIN_EN;
  logic [1:0]      PIN_SEL;
  logic            ADVANCE;
  logic [15:0]     HEX;
  logic [1:0]      CUR_SRC;
  logic            DISPLAY_ON;

  logic [15:0]     src_dat [NSRC];

  int unsigned     n_checks;
  int unsigned     n_errors;

  // Reference model: mode 0 = nothing shown, 1 = rotating, 2 = pinned.
  int              m_mode;
  int              m_cur;
  int              m_cnt;
  logic [15:0]     m_hex;
  logic            m_on;

  hex_display_scheduler #(
    .NUM_SRC      (NSRC),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SRC_VALID  (SRC_VALID),
    .SRC_DATA   (SRC_DATA),
    .PIN_EN     (PIN_EN),
    .PIN_SEL    (PIN_SEL),
    .ADVANCE    (ADVANCE),
    .HEX        (HEX),
    .CUR_SRC    (CUR_SRC),
    .DISPLAY_ON (DISPLAY_ON)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    SRC_DATA = '0;
    for (int i = 0; i < NSRC; i++) SRC_DATA[16*i +: 16] = src_dat[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_next(input int c, input logic [3:0] v);
    for (int k = 1; k <= NSRC; k++) begin
      if (v[(c + k) % NSRC]) return (c + k) % NSRC;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cur  = 0;
    m_cnt  = 0;
    m_hex  = 16'h0000;
    m_on   = 1'b0;
  endtask

  task automatic model_step();
    int lowest;
    lowest = 0;
    for (int i = NSRC - 1; i >= 0; i--) if (SRC_VALID[i]) lowest = i;
    if (m_mode == 0) begin
      if (PIN_EN) begin
        m_mode = 2; m_cur = int'(PIN_SEL); m_cnt = 0;
      end else if (SRC_VALID != 0) begin
        m_mode = 1; m_cur = lowest; m_cnt = 0;
      end
    end else if (m_mode == 1) begin
      if (PIN_EN) begin
        m_mode = 2; m_cur = int'(PIN_SEL); m_cnt = 0;
      end else if (!SRC_VALID[m_cur]) begin
        if (SRC_VALID == 0) m_mode = 0;
        else m_cur = ref_next(m_cur, SRC_VALID);
        m_cnt = 0;
      end else if (m_cnt == DWELL - 1 || ADVANCE) begin
        m_cur = ref_next(m_cur, SRC_VALID); m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (PIN_EN) begin
        m_cur = int'(PIN_SEL);
      end else if (SRC_VALID[m_cur]) begin
        m_mode = 1;
      end else if (SRC_VALID != 0) begin
        m_mode = 1; m_cur = ref_next(m_cur, SRC_VALID);
      end else begin
        m_mode = 0;
      end
      m_cnt = 0;
    end
    m_on  = (m_mode != 0);
    m_hex = m_on ? src_dat[m_cur] : 16'h0000;
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #2;
    check("hex", 32'(HEX), 32'(m_hex));
    check("display_on", 32'(DISPLAY_ON), 32'(m_on));
    if (m_on) check("cur_src", 32'(CUR_SRC), 32'(m_cur));
  endtask

  initial begin
    bit found;
    n_checks  = 0;
    n_errors  = 0;
    RST       = 1'b1;
    SRC_VALID = '0;
    PIN_EN    = 1'b0;
    PIN_SEL   = '0;
    ADVANCE   = 1'b0;
    for (int i = 0; i < NSRC; i++) src_dat[i] = 16'(16'h1111 * i);
    model_reset();

    // Reset state
    #12;
    check("rst_hex", 32'(HEX), 32'h0);
    check("rst_cur", 32'(CUR_SRC), 32'h0);
    check("rst_on", 32'(DISPLAY_ON), 32'h0);
    RST = 1'b0;
    tick();
    SRC_VALID = 4'b1111;
    tick();
    check("first_hex", 32'(HEX), 32'h0000);
    check("first_on", 32'(DISPLAY_ON), 32'h1);

    // Full rotation, 4 cycles per source
    for (int i = 2; i <= 17; i++) begin
      tick();
      check("rot_cur", 32'(CUR_SRC), 32'(((i - 1) / DWELL) % NSRC));
      check("rot_hex", 32'(HEX), 32'(16'h1111 * (((i - 1) / DWELL) % NSRC)));
    end

    // Skip and drop
    SRC_VALID = 4'b1010;
    tick();
    check("skip_cur1", 32'(CUR_SRC), 32'd1);
    for (int i = 0; i < DWELL; i++) tick();
    check("skip_cur3", 32'(CUR_SRC), 32'd3);
    tick();
    SRC_VALID = 4'b0010;
    tick();
    check("drop_cur", 32'(CUR_SRC), 32'd1);
    check("drop_hex", 32'(HEX), 32'h1111);
    for (int i = 0; i < DWELL - 1; i++) begin
      tick();
      check("drop_hold", 32'(CUR_SRC), 32'd1);
    end
    SRC_VALID = 4'b0000;
    tick();
    check("idle_hex", 32'(HEX), 32'h0);
    check("idle_on", 32'(DISPLAY_ON), 32'h0);

    // ADVANCE on the dwell-expiry cycle of source 1
    SRC_VALID = 4'b1111;
    tick();
    for (int i = 0; i < DWELL; i++) tick();
    check("adv_on1", 32'(CUR_SRC), 32'd1);
    for (int i = 0; i < DWELL - 1; i++) tick();
    ADVANCE = 1'b1;
    tick();
    ADVANCE = 1'b0;
    check("adv_collide", 32'(CUR_SRC), 32'd2);
    tick();
    tick();
    check("adv_hold", 32'(CUR_SRC), 32'd2);
    ADVANCE = 1'b1;
    tick();
    ADVANCE = 1'b0;
    check("adv_mid", 32'(CUR_SRC), 32'd3);

    // Pin override on an invalid source with live data change
    PIN_EN    = 1'b1;
    PIN_SEL   = 2'd2;
    SRC_VALID = 4'b1011;
    tick();
    check("pin_cur", 32'(CUR_SRC), 32'd2);
    check("pin_hex", 32'(HEX), 32'h2222);
    for (int i = 0; i < DWELL + 1; i++) tick();
    check("pin_hold", 32'(CUR_SRC), 32'd2);
    src_dat[2] = 16'hBEEF;
    tick();
    check("pin_live", 32'(HEX), 32'hBEEF);
    PIN_EN = 1'b0;
    tick();
    check("unpin_cur", 32'(CUR_SRC), 32'd3);
    check("unpin_hex", 32'(HEX), 32'h3333);
    src_dat[2] = 16'h2222;

    // Asynchronous reset while source 2 is shown
    SRC_VALID = 4'b1111;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_cur == 2 && m_mode == 1) found = 1'b1;
    end
    check("reach_src2", 32'(found), 32'h1);
    #1;
    RST = 1'b1;
    #1;
    model_reset();
    check("arst_hex", 32'(HEX), 32'h0);
    check("arst_cur", 32'(CUR_SRC), 32'h0);
    check("arst_on", 32'(DISPLAY_ON), 32'h0);
    #1;
    RST = 1'b0;
    for (int i = 0; i < DWELL; i++) begin
      tick();
      check("restart_cur0", 32'(CUR_SRC), 32'd0);
    end
    tick();
    check("restart_cur1", 32'(CUR_SRC), 32'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) SRC_VALID = 4'($urandom);
      ADVANCE = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) PIN_EN = ~PIN_EN;
      if ($urandom_range(0, 3) == 0) PIN_SEL = 2'($urandom);
      if ($urandom_range(0, 5) == 0) src_dat[$urandom_range(0, NSRC - 1)] = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
